// File: rtl/apb_mem_completer.sv
// APB completer bridging APB transfers to a single-cycle memory-model port.
// Optional `APB_ERR_EN: setups to addresses >= MEM_DEPTH get an immediate PSLVERR response.
module apb_mem_completer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned SEL_INDEX   = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned MEM_DEPTH   = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [SEL_WIDTH-1:0]  i_psel,
  input  logic                  i_penable,
  input  logic                  i_pwrite,
  input  logic [ADDR_WIDTH-1:0] i_paddr,
  input  logic [DATA_WIDTH-1:0] i_pwdata,
  output logic [DATA_WIDTH-1:0] o_prdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic                  o_mem_en,
  output logic                  o_mem_wr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data_w,
  input  logic [DATA_WIDTH-1:0] i_mem_data_r
);

  localparam int unsigned CNT_WIDTH = 4;

  typedef enum logic [1:0] {IDLE, MEM, LAT, RESP} state_e;

  // Elaboration-time sanity check on configuration.
  if (WAIT_STATES > 15 || MEM_DEPTH == 0) begin : g_bad_cfg
    $error("apb_mem_completer: WAIT_STATES must be 0..15 and MEM_DEPTH nonzero");
  end

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_w_q, mem_data_w_d;

  logic sel;
  logic active;
  logic addr_err;
  logic unused_psel;

  assign sel         = i_psel[SEL_INDEX];
  assign active      = sel & i_penable;
  assign unused_psel = ^i_psel;

`ifdef APB_ERR_EN
  assign addr_err = (64'(i_paddr) >= 64'(MEM_DEPTH));
`else
  assign addr_err = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prdata_d     = prdata_q;
    pready_d     = pready_q;
    pslverr_d    = pslverr_q;
    mem_en_d     = mem_en_q;
    mem_wr_d     = mem_wr_q;
    mem_addr_d   = mem_addr_q;
    mem_data_w_d = mem_data_w_q;
    unique case (state_q)
      IDLE: begin
        if (sel && !i_penable) begin
          if (addr_err) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
          end else begin
            state_d      = MEM;
            mem_en_d     = 1'b1;
            mem_wr_d     = i_pwrite;
            mem_addr_d   = i_paddr;
            mem_data_w_d = i_pwdata;
          end
        end
      end
      MEM: begin
        mem_en_d = 1'b0;
        if (!active) begin
          state_d = IDLE;
        end else begin
          cnt_d   = CNT_WIDTH'(WAIT_STATES);
          state_d = LAT;
        end
      end
      LAT: begin
        if (!active) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
          prdata_d = mem_wr_q ? '0 : i_mem_data_r;
          pready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        mem_wr_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      prdata_q     <= '0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_w_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prdata_q     <= prdata_d;
      pready_q     <= pready_d;
      pslverr_q    <= pslverr_d;
      mem_en_q     <= mem_en_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_w_q <= mem_data_w_d;
    end
  end

  assign o_prdata     = prdata_q;
  assign o_pready     = pready_q;
  assign o_pslverr    = pslverr_q;
  assign o_mem_en     = mem_en_q;
  assign o_mem_wr     = mem_wr_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data_w = mem_data_w_q;

endmodule

// File: tb/tb_apb_mem_completer.sv
// Bench for apb_mem_completer: instance 0 (PSEL[0], no wait states), instance 1 (PSEL[1], 2 wait states).
module tb_apb_mem_completer;

  logic        clk;
  logic        rst_n;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;

  logic [1:0][31:0] prdata;
  logic [1:0]       pready;
  logic [1:0]       pslverr;
  logic [1:0]       mem_en;
  logic [1:0]       mem_wr;
  logic [1:0][15:0] mem_addr;
  logic [1:0][31:0] mem_dw;
  logic [1:0][31:0] mem_dr;

  logic [31:0] mem0 [0:65535];
  logic [31:0] mem1 [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mem_completer #(.SEL_INDEX(0), .WAIT_STATES(0), .MEM_DEPTH(256)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata[0]), .o_pready(pready[0]),
    .o_pslverr(pslverr[0]), .o_mem_en(mem_en[0]), .o_mem_wr(mem_wr[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_data_w(mem_dw[0]), .i_mem_data_r(mem_dr[0]));

  apb_mem_completer #(.SEL_INDEX(1), .WAIT_STATES(2), .MEM_DEPTH(256)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata), .o_prdata(prdata[1]), .o_pready(pready[1]),
    .o_pslverr(pslverr[1]), .o_mem_en(mem_en[1]), .o_mem_wr(mem_wr[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_data_w(mem_dw[1]), .i_mem_data_r(mem_dr[1]));

  // Memory models: read data appears the cycle after the strobe and holds.
  always @(posedge clk) begin
    if (mem_en[0]) begin
      if (mem_wr[0]) mem0[mem_addr[0]] <= mem_dw[0];
      else           mem_dr[0] <= mem0[mem_addr[0]];
    end
    if (mem_en[1]) begin
      if (mem_wr[1]) mem1[mem_addr[1]] <= mem_dw[1];
      else           mem_dr[1] <= mem1[mem_addr[1]];
    end
  end

  typedef struct {
    int          k;
    logic        wr;
    logic [15:0] a;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    logic        err;
    int          en;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one transfer starting in the current cycle (cycle 0 = setup); returns
  // one cycle after RESP with the bus idle, so consecutive calls are back-to-back.
  task automatic xfer(input int k, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic err,
                      output int en_cnt, output int bad_fields, output logic rdy_after,
                      output int rdy_at);
    lat = -1; rd = '0; err = 1'b0; en_cnt = 0; bad_fields = 0; rdy_at = -1;
    psel = 4'(1 << k); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        en_cnt++;
        if (mem_wr[k] !== wr || mem_addr[k] !== a || (wr && mem_dw[k] !== wd)) bad_fields++;
      end
      if (pready[k]) begin
        lat = c; rd = prdata[k]; err = pslverr[k]; rdy_at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    rdy_after = pready[k];
  endtask

  int          lat, en_cnt, bad_fields, rdy_at, rdy_at_prev;
  logic [31:0] rd;
  logic        err, rdy_after;
  int          hits;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_pready%0d", k), 32'(pready[k]), 32'd0);
      chk($sformatf("reset_mem_en%0d", k), 32'(mem_en[k]), 32'd0);
      chk($sformatf("reset_prdata%0d", k), prdata[k], 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // {inst, write, addr, wdata, ready cycle, prdata, pslverr, mem_en pulses}
    vecs.push_back('{0, 1'b1, 16'h0001, 32'hDEADBEEF, 3, 32'h0, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 16'h0001, 32'h0,        3, 32'hDEADBEEF, 1'b0, 1});
    vecs.push_back('{1, 1'b1, 16'h0002, 32'h12345678, 5, 32'h0, 1'b0, 1});
    vecs.push_back('{1, 1'b0, 16'h0002, 32'h0,        5, 32'h12345678, 1'b0, 1});
    vecs.push_back('{0, 1'b1, 16'h00FF, 32'hA5A5A5A5, 3, 32'h0, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 16'h00FF, 32'h0,        3, 32'hA5A5A5A5, 1'b0, 1});
`ifdef APB_ERR_EN
    vecs.push_back('{0, 1'b1, 16'h0100, 32'h0BADC0DE, 1, 32'h0, 1'b1, 0});
    vecs.push_back('{0, 1'b0, 16'h0100, 32'h0,        1, 32'h0, 1'b1, 0});
    vecs.push_back('{1, 1'b0, 16'h0100, 32'h0,        1, 32'h0, 1'b1, 0});
`else
    vecs.push_back('{0, 1'b1, 16'h0100, 32'h0BADC0DE, 3, 32'h0, 1'b0, 1});
    vecs.push_back('{0, 1'b0, 16'h0100, 32'h0,        3, 32'h0BADC0DE, 1'b0, 1});
    vecs.push_back('{1, 1'b0, 16'h0002, 32'h0,        5, 32'h12345678, 1'b0, 1});
`endif

    foreach (vecs[i]) begin
      xfer(vecs[i].k, vecs[i].wr, vecs[i].a, vecs[i].wd, lat, rd, err, en_cnt, bad_fields,
           rdy_after, rdy_at);
      chk($sformatf("v%0d_ready_cycle", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_prdata", i), rd, vecs[i].rd);
      chk($sformatf("v%0d_pslverr", i), 32'(err), 32'(vecs[i].err));
      chk($sformatf("v%0d_mem_en_pulses", i), 32'(en_cnt), 32'(vecs[i].en));
      chk($sformatf("v%0d_mem_fields", i), 32'(bad_fields), 32'd0);
      chk($sformatf("v%0d_pready_drop", i), 32'(rdy_after), 32'd0);
    end

    // Back-to-back: second setup in the cycle after RESP.
    xfer(0, 1'b1, 16'h0004, 32'hCAFEF00D, lat, rd, err, en_cnt, bad_fields, rdy_after, rdy_at_prev);
    xfer(0, 1'b0, 16'h0004, 32'h0, lat, rd, err, en_cnt, bad_fields, rdy_after, rdy_at);
    chk("b2b_ready_gap", 32'(rdy_at - rdy_at_prev), 32'd4);
    chk("b2b_ready_cycle", 32'(lat), 32'd3);
    chk("b2b_prdata", rd, 32'hCAFEF00D);

    // Setup with PENABLE already high is ignored.
    psel = 4'b0001; penable = 1'b1; pwrite = 1'b0; paddr = 16'h0001;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_en[0] || pready[0]) hits++;
    end
    chk("protocol_violation_ignored", 32'(hits), 32'd0);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;

    // Abort: PENABLE dropped in cycle 2 of a read.
    psel = 4'b0001; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("abort_mem_en_c1", 32'(mem_en[0]), 32'd1);
    @(posedge clk); #1;
    psel = '0; penable = 1'b0;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (pready[0]) hits++;
    end
    chk("abort_no_pready", 32'(hits), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 16'h0001, 32'h0, lat, rd, err, en_cnt, bad_fields, rdy_after, rdy_at);
    chk("after_abort_ready_cycle", 32'(lat), 32'd3);
    chk("after_abort_prdata", rd, 32'hDEADBEEF);

    // Reset while instance 1 sits in LAT of a write.
    psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0002; pwdata = 32'h77777777;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_lat_pready", 32'(pready[1]), 32'd0);
    chk("rst_lat_mem_en", 32'(mem_en[1]), 32'd0);
    chk("rst_lat_mem_wr", 32'(mem_wr[1]), 32'd0);
    chk("rst_lat_mem_addr", 32'(mem_addr[1]), 32'd0);
    chk("rst_lat_mem_data_w", mem_dw[1], 32'd0);
    chk("rst_lat_prdata", prdata[1], 32'd0);
    chk("rst_lat_prdata_inst0", prdata[0], 32'd0);
    psel = '0; penable = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b1, 16'h0003, 32'h55AA55AA, lat, rd, err, en_cnt, bad_fields, rdy_after, rdy_at);
    chk("post_rst_wr_ready_cycle", 32'(lat), 32'd5);
    chk("post_rst_wr_fields", 32'(bad_fields), 32'd0);
    xfer(1, 1'b0, 16'h0003, 32'h0, lat, rd, err, en_cnt, bad_fields, rdy_after, rdy_at);
    chk("post_rst_rd_ready_cycle", 32'(lat), 32'd5);
    chk("post_rst_rd_prdata", rd, 32'h55AA55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
